// File: rtl/seven_seg_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_ctrl_if
// Load/busy handshake between a datapath result source and the display
// controller.
//   load   : request to convert bin_in (honoured only while busy is low)
//   bin_in : unsigned binary value to display
//   busy   : conversion in progress
// Modports: master = value source, slave = display controller.
// ----------------------------------------------------------------------------
interface seven_seg_scan_ctrl_if #(
   parameter int BIN_W = 16
);
   logic             load;
   logic [BIN_W-1:0] bin_in;
   logic             busy;

   modport master (output load, output bin_in, input  busy);
   modport slave  (input  load, input  bin_in, output busy);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Multiplexed 7-segment display controller. A binary value accepted over the
// load/busy handshake is converted to BCD by a sequential shift-add-3 engine,
// held in a display register and scanned across DIGITS common digits.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : seven_seg_scan_ctrl_if.slave (load, bin_in, busy)
//   overflow : displayed value >= 10^DIGITS
//   digit    : one-hot digit enable, digit[0] = ones (rightmost)
//   seg_data : segments {a,b,c,d,e,f,g}, active-high
// Build option: define SEG_LZB_EN for leading-zero blanking.
// ----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
   parameter int BIN_W        = 16,
   parameter int DIGITS       = 8,
   parameter int REFRESH_BITS = 17
) (
   input  logic                   clk,
   input  logic                   reset_n,
   seven_seg_scan_ctrl_if.slave   bus,
   output logic                   overflow,
   output logic [DIGITS-1:0]      digit,
   output logic [6:0]             seg_data
);
   // Scratch holds enough nibbles for any BIN_W-bit value; it is widened to
   // at least DIGITS nibbles so the display copy never reads past it.
   localparam int SCR_N = (BIN_W + 2) / 3;
   localparam int EXT_N = (SCR_N > DIGITS) ? SCR_N : DIGITS;
   localparam int SCR_W = EXT_N * 4;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int IDX_W = $clog2(DIGITS);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2} state_t;

   state_t                  state_r, state_nx_s;
   logic [BIN_W-1:0]        bin_r, bin_nx_s;
   logic [SCR_W-1:0]        scr_r, scr_nx_s, adj_s;
   logic [CNT_W-1:0]        cnt_r, cnt_nx_s;
   logic [DIGITS*4-1:0]     disp_r, disp_nx_s;
   logic                    ovf_r, ovf_nx_s, ovf_s;
   logic                    busy_r;
   logic [REFRESH_BITS-1:0] pre_r;
   logic [IDX_W-1:0]        idx_r, idx_nx_s, pos_s;
   logic [DIGITS-1:0]       digit_r, digit_nx_s;
   logic [6:0]              seg_r, seg_nx_s;
   logic [3:0]              nib_s;
   logic                    blank_s;
   logic [SCR_W+BIN_W-1:0]  cat_s;
`ifdef SEG_LZB_EN
   logic                    hi_zero_s;
`endif

   function automatic logic [3:0] add3(input logic [3:0] n);
      if (n >= 4'd5) begin
         return n + 4'd3;
      end else begin
         return n;
      end
   endfunction

   function automatic logic [6:0] seg_enc(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110010;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   // Conversion FSM next-state and datapath next values.
   always_comb begin
      state_nx_s = state_r;
      bin_nx_s   = bin_r;
      scr_nx_s   = scr_r;
      cnt_nx_s   = cnt_r;
      disp_nx_s  = disp_r;
      ovf_nx_s   = ovf_r;
      adj_s      = '0;
      ovf_s      = 1'b0;
      for (int i = 0; i < EXT_N; i++) begin
         adj_s[i*4 +: 4] = add3(scr_r[i*4 +: 4]);
         if (i >= DIGITS) begin
            ovf_s = ovf_s | (scr_r[i*4 +: 4] != 4'd0);
         end else begin
            ovf_s = ovf_s;
         end
      end
      // Shift the adjusted scratch and remaining binary bits as one vector.
      cat_s = {adj_s, bin_r} << 1;
      case (state_r)
         IDLE: begin
            if (bus.load) begin
               bin_nx_s   = bus.bin_in;
               scr_nx_s   = '0;
               cnt_nx_s   = CNT_W'(BIN_W);
               state_nx_s = SHIFT;
            end else begin
               state_nx_s = IDLE;
            end
         end
         SHIFT: begin
            scr_nx_s = cat_s[SCR_W+BIN_W-1 -: SCR_W];
            bin_nx_s = cat_s[BIN_W-1:0];
            cnt_nx_s = cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
               state_nx_s = LATCH;
            end else begin
               state_nx_s = SHIFT;
            end
         end
         LATCH: begin
            disp_nx_s  = scr_r[DIGITS*4-1:0];
            ovf_nx_s   = ovf_s;
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Scan index advance and segment/digit next values for the active digit.
   always_comb begin
      idx_nx_s = idx_r;
      if (pre_r == {REFRESH_BITS{1'b1}}) begin
         if (idx_r == IDX_W'(DIGITS - 1)) begin
            idx_nx_s = '0;
         end else begin
            idx_nx_s = idx_r + IDX_W'(1);
         end
      end else begin
         idx_nx_s = idx_r;
      end
      // Index 0 drives the leftmost digit.
      pos_s      = IDX_W'(DIGITS - 1) - idx_r;
      digit_nx_s = DIGITS'(1) << pos_s;
      nib_s      = 4'd0;
      for (int j = 0; j < DIGITS; j++) begin
         if (IDX_W'(j) == pos_s) begin
            nib_s = disp_r[j*4 +: 4];
         end else begin
            nib_s = nib_s;
         end
      end
`ifdef SEG_LZB_EN
      hi_zero_s = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
         if (IDX_W'(j) >= pos_s) begin
            hi_zero_s = hi_zero_s & (disp_r[j*4 +: 4] == 4'd0);
         end else begin
            hi_zero_s = hi_zero_s;
         end
      end
      // The ones digit is never blanked so a zero value still shows "0".
      blank_s = (pos_s != IDX_W'(0)) && hi_zero_s;
`else
      blank_s = 1'b0;
`endif
      if (ovf_r) begin
         seg_nx_s = 7'b0000001;
      end else if (blank_s) begin
         seg_nx_s = 7'b0000000;
      end else begin
         seg_nx_s = seg_enc(nib_s);
      end
   end

   // State, datapath, scan and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
         bin_r   <= '0;
         scr_r   <= '0;
         cnt_r   <= '0;
         disp_r  <= '0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         pre_r   <= '0;
         idx_r   <= '0;
         digit_r <= '0;
         seg_r   <= 7'b0000000;
      end else begin
         state_r <= state_nx_s;
         bin_r   <= bin_nx_s;
         scr_r   <= scr_nx_s;
         cnt_r   <= cnt_nx_s;
         disp_r  <= disp_nx_s;
         ovf_r   <= ovf_nx_s;
         busy_r  <= (state_nx_s != IDLE);
         pre_r   <= pre_r + REFRESH_BITS'(1);
         idx_r   <= idx_nx_s;
         digit_r <= digit_nx_s;
         seg_r   <= seg_nx_s;
      end
   end

   assign bus.busy = busy_r;
   assign overflow = ovf_r;
   assign digit    = digit_r;
   assign seg_data = seg_r;
endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Parametrised multiplexed 7-segment display controller, next generation of `seven_seg_display`. It accepts an unsigned binary value through a load/busy handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. The converted value is held in a display register and scanned across `DIGITS` common digits at a programmable refresh rate, with overflow indication. It sits between datapath result registers and the board's segment/digit pins.

## Interface
- `BIN_W`, 16, width of the binary input (≥ 1)
- `DIGITS`, 8, number of display digits (2–16; need not be a power of two)
- `REFRESH_BITS`, 17, each digit is active for 2^`REFRESH_BITS` clock cycles (≥ 1)
- `clk`  in  1  single system clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `load`  in  1  request to convert `bin_in`; sampled only while `busy`=0
- `bin_in`  in  `BIN_W`  unsigned value to display
- `busy`  out  1  conversion in progress
- `overflow`  out  1  displayed value ≥ 10^`DIGITS`
- `digit`  out  `DIGITS`  one-hot digit enable, active-high; `digit[0]` = ones (rightmost)
- `seg_data`  out  7  segments {a,b,c,d,e,f,g}, active-high

## Operation
- Conversion FSM, states IDLE → SHIFT → LATCH → IDLE.
  - IDLE: `busy`=0. On `load`=1: capture `bin_in`, clear BCD scratch, shift count = `BIN_W`, go to SHIFT.
  - SHIFT: per cycle, add 3 to every scratch nibble ≥ 5, then shift {scratch, bin} left by one. After `BIN_W` shifts, go to LATCH.
  - LATCH: copy the low `DIGITS` nibbles to the display register. Set `overflow` if any scratch nibble above `DIGITS` is nonzero. Return to IDLE.
- Scratch holds ceil(`BIN_W`/3) nibbles, so no conversion result is lost internally.
- `busy` is 1 in SHIFT and LATCH. `load` outside IDLE is ignored, with no queueing.
- The display register changes only in LATCH; the old value stays on display throughout a conversion.
- Scan:
  - Prescaler counts 0..2^`REFRESH_BITS`−1 and wraps.
  - Scan index k advances when the prescaler wraps, with sequence 0..`DIGITS`−1 → 0.
  - Index k enables `digit[DIGITS-1-k]`, so scanning runs from the leftmost digit to the rightmost.
- Segment encoding:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011.
  - Blank = 0000000.
  - When `overflow`=1, every digit shows a dash, 0000001.
- `digit` and `seg_data` are registered.

## Timing
- Reset values: `busy`=0, `overflow`=0, `digit`=0, `seg_data`=0000000. Reset also clears the display register, prescaler, scan index and FSM (→ IDLE).
- `reset_n` low mid-conversion aborts it. The value shown afterwards is 0.
- First edge after `reset_n` rises: `digit` = 1<<(`DIGITS`−1).
- Conversion latency, with `load` sampled at edge E0:
  - `busy`=1 after E0.
  - Shifts occur at E1..E`BIN_W`.
  - The display register and `overflow` update at E`BIN_W`+1, and `busy` falls at the same edge.
  - `busy` is therefore high for exactly `BIN_W`+1 cycles.
- `load` in the cycle right after `busy` falls is accepted.
- Registered outputs lag the scan index and display register by 1 cycle.
- A display update while a digit is active is reflected on `seg_data` at the next edge. It does not wait for a scan boundary.
- Scan index wrap for non-power-of-two `DIGITS`: after `DIGITS`−1 comes 0; indices ≥ `DIGITS` never occur.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking.
  - A digit is blank if it and every more-significant digit are 0.
  - `digit[0]` is never blanked, so value 0 shows a single "0".
  - Dashes on overflow take priority over blanking.
- `SEG_LZB_EN` undefined: every digit shows its nibble, leading zeros included.
  - Post-reset `seg_data` after the first scan output is 1111110.

## Test plan
- `DIGITS`=3, `REFRESH_BITS`=1: hold `reset_n`=0 for 3 cycles → `digit`=000, `seg_data`=0, `busy`=0. After release, `digit` steps 100,100,010,010,001,001,100 (index wraps 2→0).
- `BIN_W`=8, `DIGITS`=4, load 255 → `busy` high exactly 9 cycles. Then, with `SEG_LZB_EN`: `digit[3]` 0000000, `digit[2]` 1101101, `digit[1]` 1011011, `digit[0]` 1011011, `overflow`=0.
- Load 0 → with `SEG_LZB_EN`, only `digit[0]` shows 1111110 and the others show 0000000. Without the macro, all four digits show 1111110.
- `BIN_W`=8, `DIGITS`=2, load 123 → `overflow`=1, both digits 0000001. Then load 99 → `overflow`=0, both digits 1111011.
- Load 200, then pulse `load` with 7 on cycles 3 and 9 (still busy) → both pulses ignored, display shows 200. A `load` of 7 on the first cycle with `busy`=0 is accepted → display shows 7.
- Load 255, then assert `reset_n`=0 during SHIFT cycle 4 → next edge `busy`=0, `digit`=0. After release, the display shows 0 and a new load of 42 converts in 9 cycles.
